// File: rtl/bus_arbiter_wrr.sv
// bus_arbiter_wrr: weighted round-robin bus arbiter with a registered one-hot grant
// and per-master priority and burst quota that can be programmed at runtime.
module bus_arbiter_wrr #(
    parameter int NUM_MASTERS = 4,
    parameter int ID_W        = $clog2(NUM_MASTERS),
    parameter int CFG_ADDR_W  = $clog2(NUM_MASTERS + 1)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_MASTERS-1:0] req,
    output logic [NUM_MASTERS-1:0] grant,
    output logic                   grant_valid,
    output logic [ID_W-1:0]        grant_id,
    input  logic                   config_wr,
    input  logic [CFG_ADDR_W-1:0]  config_addr,
    input  logic [7:0]             config_data
);
    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] OWNED = 1'b1;
    typedef logic [NUM_MASTERS-1:0][7:0] cfg_t;

    cfg_t                   cfg_q, cfg_d;
    logic [1:0]             ctrl_q, ctrl_d;
    logic [0:0]             state_q, state_d;
    logic [NUM_MASTERS-1:0] grant_q, grant_d;
    logic                   valid_q, valid_d;
    logic [ID_W-1:0]        id_q, id_d, ptr_q, ptr_d, win;
    logic [5:0]             cnt_q, cnt_d, quota_q, quota_d, win_quota;
    logic [NUM_MASTERS-1:0] cand;
    logic                   own_req, grab;

    // First requester after ptr in circular order; in priority mode only the highest prio level is eligible.
    function automatic logic [ID_W-1:0] pick(input logic [NUM_MASTERS-1:0] m, input logic [ID_W-1:0] ptr,
                                             input logic prio_mode, input cfg_t cfg);
        logic [1:0] best;
        logic       found;
        int         idx;
        best  = '0;
        found = 1'b0;
        pick  = ptr;
        for (int i = 0; i < NUM_MASTERS; i++)
            if (m[i] && cfg[i][7:6] > best) best = cfg[i][7:6];
        for (int i = 1; i <= NUM_MASTERS; i++) begin
            idx = (int'(ptr) + i) % NUM_MASTERS;
            if (!found && m[idx] && (!prio_mode || cfg[idx][7:6] == best)) begin
                found = 1'b1;
                pick  = ID_W'(idx);
            end
        end
    endfunction

    always_comb begin
        cand      = req & ~grant_q;
        own_req   = |(req & grant_q);
        win       = pick(cand, ptr_q, ctrl_q[1], cfg_q);
        win_quota = (cfg_q[win][5:0] == 6'd0) ? 6'd1 : cfg_q[win][5:0];
        grab      = |cand && (state_q == IDLE || !own_req || cnt_q == 6'd0);
        state_d   = state_q;
        grant_d   = grant_q;
        id_d      = id_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        quota_d   = quota_q;
        if (!ctrl_q[0]) begin
            state_d = IDLE;
            grant_d = '0;
        end else if (grab) begin
            state_d = OWNED;
            grant_d = NUM_MASTERS'(1) << win;
            id_d    = win;
            ptr_d   = win;
            quota_d = win_quota;
            cnt_d   = win_quota - 6'd1;
        end else if (state_q == OWNED) begin
            state_d = own_req ? OWNED : IDLE;
            grant_d = own_req ? grant_q : '0;
            cnt_d   = (cnt_q == 6'd0) ? quota_q - 6'd1 : cnt_q - 6'd1;
        end
        valid_d = |grant_d;
        cfg_d   = cfg_q;
        ctrl_d  = ctrl_q;
        for (int i = 0; i < NUM_MASTERS; i++)
            if (config_wr && config_addr == CFG_ADDR_W'(i)) cfg_d[i] = config_data;
        if (config_wr && config_addr == CFG_ADDR_W'(NUM_MASTERS)) ctrl_d = config_data[1:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cfg_q   <= {NUM_MASTERS{8'h04}};
            ctrl_q  <= 2'b01;
            state_q <= IDLE;
            grant_q <= '0;
            valid_q <= 1'b0;
            id_q    <= '0;
            ptr_q   <= ID_W'(NUM_MASTERS - 1);
            cnt_q   <= '0;
            quota_q <= 6'd1;
        end else begin
            cfg_q   <= cfg_d;
            ctrl_q  <= ctrl_d;
            state_q <= state_d;
            grant_q <= grant_d;
            valid_q <= valid_d;
            id_q    <= id_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            quota_q <= quota_d;
        end
    end

    assign grant       = grant_q;
    assign grant_valid = valid_q;
    assign grant_id    = id_q;
endmodule
